// File: rtl/mips_isa_pkg.sv
// MIPS-style instruction constants shared by the split queue and its field decoder.
// Holds opcode values, field bit positions and the decoded-instruction record.
package mips_isa_pkg;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JIDX_HI   = 25;
  localparam int JIDX_LO   = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [31:0] jtarget;
    logic [31:0] pc;
  } decoded_inst_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic imm_is_zero_ext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

  function automatic logic is_jump(input logic [5:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/inst_split_queue_if.sv
// Producer/consumer bundle for the instruction split queue.
// The queue uses the slave modport; the fetch/issue side uses master.
interface inst_split_queue_if #(
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode_out;
  logic [5:0]       funct_out;
  logic [4:0]       rs_out;
  logic [4:0]       rt_out;
  logic [4:0]       rd_out;
  logic [4:0]       shamt_out;
  logic [31:0]      imm_out;
  logic [31:0]      jtarget_out;
  logic [31:0]      pc_out;
  logic [CNT_W-1:0] count_out;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, opcode_out, funct_out, rs_out, rt_out, rd_out,
           shamt_out, imm_out, jtarget_out, pc_out, count_out
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, opcode_out, funct_out, rs_out, rt_out, rd_out,
           shamt_out, imm_out, jtarget_out, pc_out, count_out
  );
endinterface

// File: rtl/inst_field_decode.sv
// Purely combinational split of one buffered instruction into its fields,
// extended immediate and jump target.
module inst_field_decode
  import mips_isa_pkg::*;
(
  input  logic [31:0]   inst,
  input  logic [31:0]   pc,
  output decoded_inst_t dec
);

  logic [5:0] opcode;
  logic [3:0] pc_plus4_hi;

  assign opcode = inst[OPCODE_HI:OPCODE_LO];

  // Adding 4 only reaches bit 28 when pc[27:2] is all ones, so only the top nibble is formed.
  assign pc_plus4_hi = pc[31:28] + {3'b000, &pc[27:2]};

  always_comb begin
    dec         = '0;
    dec.opcode  = opcode;
    dec.rs      = inst[RS_HI:RS_LO];
    dec.rt      = inst[RT_HI:RT_LO];
    dec.rd      = inst[RD_HI:RD_LO];
    dec.shamt   = inst[SHAMT_HI:SHAMT_LO];
    dec.funct   = inst[FUNCT_HI:FUNCT_LO];
    dec.imm     = imm_is_zero_ext(opcode) ? {16'h0000, inst[IMM_HI:IMM_LO]}
                                          : {{16{inst[IMM_HI]}}, inst[IMM_HI:IMM_LO]};
    dec.jtarget = {pc_plus4_hi, inst[JIDX_HI:JIDX_LO], 2'b00};
    dec.pc      = pc;
  end

endmodule

// File: rtl/inst_split_queue.sv
// Instruction buffer between fetch and issue: a DEPTH-entry FIFO of {inst, pc}
// whose head entry is presented already split into decoded fields.
module inst_split_queue
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  inst_split_queue_if.slave q
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [63:0]      mem [DEPTH];

  logic          push;
  logic          pop;
  logic [63:0]   head;
  decoded_inst_t head_dec;
  decoded_inst_t shown;

  assign q.in_ready  = (count_reg < CNT_W'(DEPTH));
  assign q.out_valid = (count_reg != '0);
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (q.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; the count alone decides which entries are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && !q.flush && (wr_ptr_reg == PTR_W'(gi)))
        mem[gi] <= {q.in_inst, q.in_pc};
    end
  end

  assign head = mem[rd_ptr_reg];

  inst_field_decode u_decode (
    .inst (head[63:32]),
    .pc   (head[31:0]),
    .dec  (head_dec)
  );

  // Stale storage must never leak out while the queue is empty.
  assign shown = q.out_valid ? head_dec : '0;

  assign q.opcode_out  = shown.opcode;
  assign q.rs_out      = shown.rs;
  assign q.rt_out      = shown.rt;
  assign q.rd_out      = shown.rd;
  assign q.shamt_out   = shown.shamt;
  assign q.funct_out   = shown.funct;
  assign q.imm_out     = shown.imm;
  assign q.jtarget_out = shown.jtarget;
  assign q.pc_out      = shown.pc;
  assign q.count_out   = count_reg;

endmodule

// File: tb/tb_inst_split_queue.sv
// Self-checking bench for inst_split_queue: directed scenarios plus a short
// random run, all checked against a scoreboard of independently decoded entries.
module tb_inst_split_queue;
  import mips_isa_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  decoded_inst_t exp_q[$];

  inst_split_queue_if #(.CNT_W(CNT_W)) q ();

  inst_split_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decoded_inst_t model(input logic [31:0] inst, input logic [31:0] pc);
    decoded_inst_t d;
    logic [31:0]   p4;
    d.opcode = inst[31:26];
    d.rs     = inst[25:21];
    d.rt     = inst[20:16];
    d.rd     = inst[15:11];
    d.shamt  = inst[10:6];
    d.funct  = inst[5:0];
    if (d.opcode == 6'h0C || d.opcode == 6'h0D || d.opcode == 6'h0E)
      d.imm = {16'h0000, inst[15:0]};
    else
      d.imm = {{16{inst[15]}}, inst[15:0]};
    p4        = pc + 32'd4;
    d.jtarget = {p4[31:28], inst[25:0], 2'b00};
    d.pc      = pc;
    return d;
  endfunction

  // One clock of stimulus, entered and left just after a falling edge.
  // Captures the head as presented before the edge; updates the scoreboard from the model's own occupancy.
  task automatic cycle(input logic push, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pop, input logic do_flush,
                       output logic popped, output decoded_inst_t obs);
    q.in_valid  = push;
    q.in_inst   = inst;
    q.in_pc     = pc;
    q.out_ready = pop;
    q.flush     = do_flush;
    #1;
    obs.opcode  = q.opcode_out;
    obs.rs      = q.rs_out;
    obs.rt      = q.rt_out;
    obs.rd      = q.rd_out;
    obs.shamt   = q.shamt_out;
    obs.funct   = q.funct_out;
    obs.imm     = q.imm_out;
    obs.jtarget = q.jtarget_out;
    obs.pc      = q.pc_out;
    if (do_flush) begin
      popped = 1'b0;
      exp_q.delete();
    end else begin
      popped = pop && (exp_q.size() != 0);
      if (push && exp_q.size() < DEPTH) exp_q.push_back(model(inst, pc));
    end
    @(negedge clk);
    q.in_valid  = 1'b0;
    q.out_ready = 1'b0;
    q.flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    q.in_valid  = 1'b1;
    q.in_inst   = 32'h2230FFFC;
    q.in_pc     = 32'h00400000;
    q.out_ready = 1'b0;
    q.flush     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (q.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", q.in_ready); end
    checks++; if (q.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", q.out_valid); end
    checks++; if (q.count_out !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", q.count_out); end
    checks++; if ({q.imm_out, q.pc_out, q.opcode_out, q.jtarget_out} !== '0) begin
      errors++; $display("FAIL reset_data got imm=%h pc=%h op=%h jt=%h want 0", q.imm_out, q.pc_out, q.opcode_out, q.jtarget_out);
    end
    q.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (q.count_out !== 3'd0 || q.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_push_dropped got count=%0d valid=%b want 0 0", q.count_out, q.out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_decode();
    logic p;
    decoded_inst_t o, e;
    cycle(1'b1, 32'h2230FFFC, 32'h00400000, 1'b0, 1'b0, p, o);
    checks++; if (q.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", q.out_valid); end
    checks++; if ({q.opcode_out, q.rs_out, q.rt_out} !== {6'h08, 5'd17, 5'd16}) begin
      errors++; $display("FAIL addi_fields got op=%h rs=%0d rt=%0d want 08 17 16", q.opcode_out, q.rs_out, q.rt_out);
    end
    checks++; if (q.imm_out !== 32'hFFFFFFFC || q.pc_out !== 32'h00400000) begin
      errors++; $display("FAIL addi_imm_pc got imm=%h pc=%h want fffffffc 00400000", q.imm_out, q.pc_out);
    end
    cycle(1'b1, 32'h3630FFFF, 32'h00400004, 1'b1, 1'b0, p, o);
    if (p) begin
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL pop_addi got %h want %h", o, e); end
    end
    checks++; if (q.opcode_out !== 6'h0D || q.imm_out !== 32'h0000FFFF) begin
      errors++; $display("FAIL ori got op=%h imm=%h want 0d 0000ffff", q.opcode_out, q.imm_out);
    end
    cycle(1'b1, 32'h08100000, 32'h90000000, 1'b1, 1'b0, p, o);
    if (p) begin
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL pop_ori got %h want %h", o, e); end
    end
    checks++; if (q.jtarget_out !== 32'h90400000) begin
      errors++; $display("FAIL j_target got %h want 90400000", q.jtarget_out);
    end
    cycle(1'b1, 32'h3A108001, 32'h00400010, 1'b1, 1'b0, p, o);
    if (p) begin
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL pop_j got %h want %h", o, e); end
    end
    checks++; if (q.imm_out !== 32'h00008001) begin
      errors++; $display("FAIL xori_imm got %h want 00008001", q.imm_out);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, o);
    if (p) begin
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL pop_xori got %h want %h", o, e); end
    end
    checks++; if ({q.out_valid, q.imm_out, q.jtarget_out, q.pc_out, q.rs_out} !== '0) begin
      errors++; $display("FAIL empty_zero got valid=%b imm=%h jt=%h pc=%h want all 0", q.out_valid, q.imm_out, q.jtarget_out, q.pc_out);
    end
    $display("test_decode done");
  endtask

  task automatic test_full();
    logic p;
    decoded_inst_t o, e;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h20000000 + 32'(i * 17), 32'h00001000 + 32'(i * 4), 1'b0, 1'b0, p, o);
      if (i == 3) begin
        checks++; if (q.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", q.in_ready); end
      end
    end
    checks++; if (q.count_out !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", q.count_out); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, o);
      checks++;
      if (!p) begin
        errors++; $display("FAIL drain_%0d got no entry want one", i);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL drain_%0d got %h want %h", i, o, e); end
      end
    end
    checks++; if (q.count_out !== 3'd0 || q.out_valid !== 1'b0) begin
      errors++; $display("FAIL drained got count=%0d valid=%b want 0 0", q.count_out, q.out_valid);
    end
    $display("test_full done");
  endtask

  task automatic test_back_to_back();
    logic p;
    decoded_inst_t o, e;
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 32'h8C000000 + 32'(i), 32'h00002000 + 32'(i * 4), 1'b0, 1'b0, p, o);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'hAC008000 + 32'(i), 32'h00003000 + 32'(i * 4), 1'b1, 1'b0, p, o);
      checks++;
      if (!p) begin
        errors++; $display("FAIL b2b_pop_%0d got no entry want one", i);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_pop_%0d got %h want %h", i, o, e); end
      end
      checks++; if (q.count_out !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d got %0d want 2", i, q.count_out); end
    end
    cycle(1'b1, 32'h24000005, 32'h00004000, 1'b0, 1'b0, p, o);
    checks++; if (q.count_out !== 3'd3) begin errors++; $display("FAIL pre_flush_count got %0d want 3", q.count_out); end
    cycle(1'b1, 32'h24000006, 32'h00004004, 1'b1, 1'b1, p, o);
    checks++; if ({q.count_out, q.out_valid, q.in_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flush got count=%0d valid=%b ready=%b want 0 0 1", q.count_out, q.out_valid, q.in_ready);
    end
    cycle(1'b1, 32'h24000007, 32'h00004008, 1'b0, 1'b0, p, o);
    checks++; if (q.pc_out !== 32'h00004008 || q.count_out !== 3'd1) begin
      errors++; $display("FAIL post_flush got pc=%h count=%0d want 00004008 1", q.pc_out, q.count_out);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, o);
    if (p) begin
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL post_flush_pop got %h want %h", o, e); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset();
    logic p;
    decoded_inst_t o, e;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h3C010000 + 32'(i), 32'h00005000 + 32'(i * 4), 1'b0, 1'b0, p, o);
    checks++; if (q.count_out !== 3'd3) begin errors++; $display("FAIL ar_count_before got %0d want 3", q.count_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({q.out_valid, q.count_out, q.in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL ar_immediate got valid=%b count=%0d ready=%b want 0 0 1", q.out_valid, q.count_out, q.in_ready);
    end
    checks++; if ({q.imm_out, q.pc_out, q.opcode_out, q.rt_out, q.jtarget_out} !== '0) begin
      errors++; $display("FAIL ar_data got imm=%h pc=%h op=%h want 0", q.imm_out, q.pc_out, q.opcode_out);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1'b1, 32'h2108FFFF, 32'h00006000, 1'b0, 1'b0, p, o);
    checks++; if (q.out_valid !== 1'b1 || q.count_out !== 3'd1) begin
      errors++; $display("FAIL ar_after got valid=%b count=%0d want 1 1", q.out_valid, q.count_out);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, o);
    checks++;
    if (!p) begin
      errors++; $display("FAIL ar_pop got no entry want one");
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL ar_pop got %h want %h", o, e); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic p;
    decoded_inst_t o, e;
    logic [31:0] inst;
    for (int i = 0; i < 200; i++) begin
      inst = $urandom();
      if ((i % 7) == 0) inst[31:26] = 6'h0C + 6'($urandom_range(0, 2));
      cycle(1'($urandom_range(0, 1)), inst, $urandom(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0), p, o);
      if (p) begin
        e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL rand_pop_%0d got %h want %h", i, o, e); end
      end
      checks++;
      if (q.count_out !== CNT_W'(exp_q.size()) || q.out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_count_%0d got %0d valid=%b want %0d", i, q.count_out, q.out_valid, exp_q.size());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_full();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
